// File: rtl/morph_pkg.sv
// Shared definitions for the two-pass morphological opening/closing datapath:
// sequencer state encoding, kernel operation codes and a width helper.
package morph_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PASS1  = 3'd1,
    ST_DRAIN1 = 3'd2,
    ST_PASS2  = 3'd3,
    ST_DRAIN2 = 3'd4,
    ST_DONE   = 3'd5
  } morph_state_t;

  localparam logic OP_ERODE  = 1'b0;
  localparam logic OP_DILATE = 1'b1;

  function automatic int clog2_min1(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/morph_addr_gen.sv
// Raster scan of one pass: row/column counters, inter-row gap and the three
// clamped row addresses (above, current, below) built from running row bases.
module morph_addr_gen
  import morph_pkg::*;
#(
  parameter int PIC_WIDTH  = 250,
  parameter int PIC_HEIGHT = 250,
  parameter int ADDR_W     = 16,
  parameter int ROW_GAP    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              restart,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr1,
  output logic [ADDR_W-1:0] rd_addr2,
  output logic [ADDR_W-1:0] rd_addr3,
  output logic              scan_done
);

  localparam int CW = clog2_min1(PIC_WIDTH);
  localparam int RW = clog2_min1(PIC_HEIGHT);
  localparam int GW = clog2_min1(ROW_GAP);
  localparam logic [CW-1:0]     C_LAST     = CW'(PIC_WIDTH - 1);
  localparam logic [RW-1:0]     R_LAST     = RW'(PIC_HEIGHT - 1);
  localparam logic [GW-1:0]     G_LAST     = GW'((ROW_GAP > 0) ? ROW_GAP - 1 : 0);
  localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(PIC_WIDTH);
  localparam logic [ADDR_W-1:0] BASE3_INIT = (PIC_HEIGHT > 1) ? ROW_STEP : '0;

  logic              active;
  logic              in_gap;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [GW-1:0]     gap_cnt;
  logic [ADDR_W-1:0] base_above;
  logic [ADDR_W-1:0] base_mid;
  logic [ADDR_W-1:0] base_below;
  logic              row_end;
  logic              row_advance;

  assign rd_en   = active & ~in_gap;
  assign row_end = rd_en & (col == C_LAST);
  // A row is finished after its final gap cycle, or after its last read when there is no gap.
  assign row_advance = (ROW_GAP == 0) ? row_end : (active & in_gap & (gap_cnt == G_LAST));
  assign scan_done   = row_advance & (row == R_LAST);

  assign rd_addr1 = base_above + ADDR_W'(col);
  assign rd_addr2 = base_mid   + ADDR_W'(col);
  assign rd_addr3 = base_below + ADDR_W'(col);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active     <= 1'b0;
      in_gap     <= 1'b0;
      col        <= '0;
      row        <= '0;
      gap_cnt    <= '0;
      base_above <= '0;
      base_mid   <= '0;
      base_below <= '0;
    end else if (restart) begin
      active     <= 1'b1;
      in_gap     <= 1'b0;
      col        <= '0;
      row        <= '0;
      gap_cnt    <= '0;
      base_above <= '0;
      base_mid   <= '0;
      base_below <= BASE3_INIT;
    end else if (row_advance) begin
      in_gap  <= 1'b0;
      gap_cnt <= '0;
      col     <= '0;
      if (row == R_LAST) begin
        active     <= 1'b0;
        row        <= '0;
        base_above <= '0;
        base_mid   <= '0;
        base_below <= '0;
      end else begin
        row        <= row + 1'b1;
        base_above <= base_mid;
        base_mid   <= base_below;
        // The row below stays clamped at the last row once it is reached.
        if ((row + 1'b1) != R_LAST) base_below <= base_below + ROW_STEP;
      end
    end else if (row_end) begin
      col     <= '0;
      in_gap  <= 1'b1;
      gap_cnt <= '0;
    end else if (in_gap) begin
      gap_cnt <= gap_cnt + 1'b1;
    end else if (rd_en) begin
      col <= col + 1'b1;
    end
  end

endmodule

// File: rtl/morph_pass_scheduler.sv
// Two-pass frame sequencer: drives one shared 3x3 min/max kernel over the frame
// twice (bank 0 -> bank 1, then bank 1 -> bank 0) for opening or closing.
module morph_pass_scheduler
  import morph_pkg::*;
#(
  parameter int PIC_WIDTH  = 250,
  parameter int PIC_HEIGHT = 250,
  parameter int ADDR_W     = 16,
  parameter int RD_LAT     = 1,
  parameter int ROW_GAP    = 2,
  parameter int DRAIN_CYC  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  output logic              busy,
  output logic              done,
  output logic              kernel_op,
  output logic              kernel_valid_in,
  input  logic              kernel_valid_out,
  output logic              rd_en,
  output logic              rd_bank,
  output logic [ADDR_W-1:0] rd_addr1,
  output logic [ADDR_W-1:0] rd_addr2,
  output logic [ADDR_W-1:0] rd_addr3,
  output logic              wr_en,
  output logic              wr_bank,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              ovf,
  output morph_state_t      state_dbg
);

  // Handshake: kernel_valid_in marks a kernel input beat RD_LAT cycles after
  // its rd_en; every kernel_valid_out beat is written at once (no backpressure).

  localparam int TOTAL = PIC_WIDTH * PIC_HEIGHT;
  localparam int WCW   = $clog2(TOTAL + 1);
  localparam int DW    = $clog2(RD_LAT + DRAIN_CYC + 1);
  localparam logic [WCW-1:0] WR_LIMIT     = WCW'(TOTAL);
  localparam logic [DW-1:0]  DRAIN_FULL   = DW'(RD_LAT + DRAIN_CYC);
  localparam logic [DW-1:0]  DRAIN_RELOAD = DW'(DRAIN_CYC);

  morph_state_t      state;
  logic              mode_q;
  logic [WCW-1:0]    wr_cnt;
  logic [DW-1:0]     drain_cnt;
  logic [RD_LAT-1:0] vin_pipe;
  logic              scan_restart;
  logic              scan_done;
  logic              drain_exit;
  logic              in_drain;

  assign state_dbg       = state;
  assign in_drain        = (state == ST_DRAIN1) | (state == ST_DRAIN2);
  assign drain_exit      = in_drain & ~kernel_valid_out & (drain_cnt == '0);
  assign scan_restart    = ((state == ST_IDLE) & start) | ((state == ST_DRAIN1) & drain_exit);
  assign wr_en           = busy & kernel_valid_out & (wr_cnt < WR_LIMIT);
  assign wr_addr         = ADDR_W'(wr_cnt);
  assign kernel_valid_in = vin_pipe[RD_LAT-1];

  morph_addr_gen #(
    .PIC_WIDTH (PIC_WIDTH),
    .PIC_HEIGHT(PIC_HEIGHT),
    .ADDR_W    (ADDR_W),
    .ROW_GAP   (ROW_GAP)
  ) u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .restart  (scan_restart),
    .rd_en    (rd_en),
    .rd_addr1 (rd_addr1),
    .rd_addr2 (rd_addr2),
    .rd_addr3 (rd_addr3),
    .scan_done(scan_done)
  );

  // Free-running delay line; deliberately not flushed across state changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vin_pipe <= '0;
    end else begin
      vin_pipe[0] <= rd_en;
      for (int i = 1; i < RD_LAT; i++) vin_pipe[i] <= vin_pipe[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      mode_q    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      kernel_op <= OP_ERODE;
      rd_bank   <= 1'b0;
      wr_bank   <= 1'b0;
      wr_cnt    <= '0;
      drain_cnt <= '0;
      ovf       <= 1'b0;
    end else begin
      if (busy & kernel_valid_out) begin
        if (wr_cnt < WR_LIMIT) wr_cnt <= wr_cnt + 1'b1;
        else                   ovf    <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            mode_q    <= mode;
            busy      <= 1'b1;
            kernel_op <= mode;
            rd_bank   <= 1'b0;
            wr_bank   <= 1'b1;
            wr_cnt    <= '0;
            ovf       <= 1'b0;
            state     <= ST_PASS1;
          end
        end
        ST_PASS1: begin
          if (scan_done) begin
            drain_cnt <= DRAIN_FULL;
            state     <= ST_DRAIN1;
          end
        end
        ST_DRAIN1: begin
          if (kernel_valid_out) begin
            drain_cnt <= DRAIN_RELOAD;
          end else if (drain_cnt == '0) begin
            rd_bank   <= 1'b1;
            wr_bank   <= 1'b0;
            kernel_op <= ~mode_q;
            wr_cnt    <= '0;
            state     <= ST_PASS2;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        ST_PASS2: begin
          if (scan_done) begin
            drain_cnt <= DRAIN_FULL;
            state     <= ST_DRAIN2;
          end
        end
        ST_DRAIN2: begin
          if (kernel_valid_out) begin
            drain_cnt <= DRAIN_RELOAD;
          end else if (drain_cnt == '0) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        ST_DONE: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          kernel_op <= OP_ERODE;
          rd_bank   <= 1'b0;
          wr_bank   <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_morph_pass_scheduler.sv
// Bench for morph_pass_scheduler: two instances (RD_LAT 1 and 3) on a 4x3 frame,
// each fed by a delaying kernel model and checked against a frame-level model.
`timescale 1ns/1ps
module tb_morph_pass_scheduler;
  import morph_pkg::*;

  localparam int W = 4, H = 3, G = 2, AW = 16, NPIX = W * H;
  localparam int LAT_A = 1, LAT_B = 3, LIMIT = 400;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, mode = 1'b0;
  initial forever #5 clk = ~clk;
  int cyc = 0;
  initial forever begin @(posedge clk); cyc++; end

  logic busy_a, done_a, kop_a, kvi_a, kvo_a, rd_en_a, rd_bank_a, wr_en_a, wr_bank_a, ovf_a;
  logic [AW-1:0] a1_a, a2_a, a3_a, wr_addr_a;
  logic busy_b, done_b, kop_b, kvi_b, kvo_b, rd_en_b, rd_bank_b, wr_en_b, wr_bank_b, ovf_b;
  logic [AW-1:0] a1_b, a2_b, a3_b, wr_addr_b;
  morph_state_t state_a, state_b;

  morph_pass_scheduler #(.PIC_WIDTH(W), .PIC_HEIGHT(H), .ADDR_W(AW), .RD_LAT(LAT_A),
                         .ROW_GAP(G), .DRAIN_CYC(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .busy(busy_a), .done(done_a),
    .kernel_op(kop_a), .kernel_valid_in(kvi_a), .kernel_valid_out(kvo_a), .rd_en(rd_en_a),
    .rd_bank(rd_bank_a), .rd_addr1(a1_a), .rd_addr2(a2_a), .rd_addr3(a3_a), .wr_en(wr_en_a),
    .wr_bank(wr_bank_a), .wr_addr(wr_addr_a), .ovf(ovf_a), .state_dbg(state_a));

  morph_pass_scheduler #(.PIC_WIDTH(W), .PIC_HEIGHT(H), .ADDR_W(AW), .RD_LAT(LAT_B),
                         .ROW_GAP(G), .DRAIN_CYC(8)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .busy(busy_b), .done(done_b),
    .kernel_op(kop_b), .kernel_valid_in(kvi_b), .kernel_valid_out(kvo_b), .rd_en(rd_en_b),
    .rd_bank(rd_bank_b), .rd_addr1(a1_b), .rd_addr2(a2_b), .rd_addr3(a3_b), .wr_en(wr_en_b),
    .wr_bank(wr_bank_b), .wr_addr(wr_addr_b), .ovf(ovf_b), .state_dbg(state_b));

  // ---------------- scoreboard state ----------------
  int checks = 0, errors = 0;

  typedef struct {
    logic bank; logic op;
    logic [AW-1:0] a1, a2, a3;
    int gap;   // idle cycles expected before this read; -1 first read of job, -2 first of pass 2
  } rd_exp_t;

  typedef struct { int r; int c; logic [AW-1:0] a1, a2, a3; } addr_vec_t;
  typedef struct { logic mode; int klat; logic stray; logic op1; logic op2; } job_vec_t;

  rd_exp_t rd_q[$];
  logic [AW:0] exp_q[$];
  logic [AW:0] exp_q_b[$];
  rd_exp_t mon_e;
  logic [AW:0] mon_w;
  logic [7:0] rd_hist_a = '0, rd_hist_b = '0, kh_a = '0, kh_b = '0;
  logic [AW-1:0] obs1 [NPIX], obs2 [NPIX], obs3 [NPIX];
  logic pass_op [2];
  logic log_en = 1'b0, extra_a = 1'b0;
  int klat_a = 2, start_cyc = 0, last_rd = 0;
  int done_cnt_a = 0, done_cnt_b = 0, exp_done_a = 0, exp_done_b = 0, rd_cnt_b = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame-level model: every read of both passes and every write, in order.
  task automatic load_job(input logic m);
    rd_exp_t e;
    rd_q.delete(); exp_q.delete(); exp_q_b.delete();
    for (int p = 0; p < 2; p++)
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++) begin
          e.bank = (p == 1);
          e.op   = (p == 0) ? m : ~m;
          e.a2   = AW'(r * W + c);
          e.a1   = AW'(((r > 0) ? r - 1 : 0) * W + c);
          e.a3   = AW'(((r < H - 1) ? r + 1 : H - 1) * W + c);
          e.gap  = (c != 0) ? 0 : (r != 0) ? G : (p == 0) ? -1 : -2;
          rd_q.push_back(e);
        end
    for (int p = 0; p < 2; p++)
      for (int a = 0; a < NPIX; a++) begin
        exp_q.push_back({(p == 0), AW'(a)});
        exp_q_b.push_back({(p == 0), AW'(a)});
      end
  endtask

  // ---------------- kernel models ----------------
  initial forever begin
    @(posedge clk); #1;
    if (!rst_n) begin kh_a = '0; kvo_a = 1'b0; end
    else begin kh_a = {kh_a[6:0], kvi_a}; kvo_a = kh_a[klat_a] | extra_a; end
  end
  initial forever begin
    @(posedge clk); #1;
    if (!rst_n) begin kh_b = '0; kvo_b = 1'b0; end
    else begin kh_b = {kh_b[6:0], kvi_b}; kvo_b = kh_b[2]; end
  end

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (!rst_n) rd_hist_a = '0;
    else begin
      check("kvi_delay_a", kvi_a, rd_hist_a[LAT_A-1]);
      rd_hist_a = {rd_hist_a[6:0], rd_en_a};
      if (rd_en_a) begin
        if (rd_q.size() == 0) check("rd_extra", rd_en_a, 1'b0);
        else begin
          mon_e = rd_q.pop_front();
          check("rd_bank", rd_bank_a, mon_e.bank);
          check("kernel_op", kop_a, mon_e.op);
          check("rd_addr1", a1_a, mon_e.a1);
          check("rd_addr2", a2_a, mon_e.a2);
          check("rd_addr3", a3_a, mon_e.a3);
          if (mon_e.gap >= 0) check("row_gap", cyc - last_rd - 1, mon_e.gap);
          else if (mon_e.gap == -1) check("first_rd_lat", cyc, start_cyc + 1);
          if (mon_e.gap < 0) pass_op[mon_e.bank] = kop_a;
          if (log_en && !mon_e.bank) begin
            obs1[mon_e.a2] = a1_a; obs2[mon_e.a2] = a2_a; obs3[mon_e.a2] = a3_a;
          end
        end
        last_rd = cyc;
      end
      if (wr_en_a) begin
        if (exp_q.size() == 0) check("wr_extra", wr_en_a, 1'b0);
        else begin mon_w = exp_q.pop_front(); check("wr_bank_addr", {wr_bank_a, wr_addr_a}, mon_w); end
      end
      if (done_a) done_cnt_a++;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) rd_hist_b = '0;
    else begin
      check("kvi_delay_b", kvi_b, rd_hist_b[LAT_B-1]);
      rd_hist_b = {rd_hist_b[6:0], rd_en_b};
      if (rd_en_b) rd_cnt_b++;
      if (wr_en_b) begin
        if (exp_q_b.size() == 0) check("wr_extra_b", wr_en_b, 1'b0);
        else begin mon_w = exp_q_b.pop_front(); check("wr_bank_addr_b", {wr_bank_b, wr_addr_b}, mon_w); end
      end
      if (done_b) done_cnt_b++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n = 0;
    while ((busy_a || busy_b) && n < LIMIT) begin @(negedge clk); n++; end
    check("idle_before_start", {busy_a, busy_b}, 2'b00);
  endtask

  task automatic run_job(input logic m, input int klat, input logic stray, input logic inj);
    int n;
    wait_idle();
    klat_a = klat;
    load_job(m);
    rd_cnt_b = 0;
    @(posedge clk); #1; start = 1'b1; mode = m; start_cyc = cyc;
    @(posedge clk); #1; start = 1'b0; mode = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("busy_rise", busy_a, 1'b1);
    check("ovf_clear", ovf_a, 1'b0);
    if (stray) begin
      n = 0;
      while (rd_q.size() > NPIX - 3 && n < LIMIT) begin @(negedge clk); n++; end
      @(posedge clk); #1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
    end
    if (inj) begin
      n = 0;
      while (exp_q.size() > NPIX && n < LIMIT) begin @(negedge clk); n++; end
      check("pass1_writes", exp_q.size(), NPIX);
      @(posedge clk); extra_a = 1'b1;
      @(negedge clk); check("ovf_no_write", wr_en_a, 1'b0);
      @(posedge clk); extra_a = 1'b0;
      @(negedge clk); check("ovf_set", ovf_a, 1'b1);
    end
    n = 0;
    while (!done_a && n < LIMIT) begin @(negedge clk); n++; end
    check("done_seen", done_a, 1'b1);
    check("busy_at_done", busy_a, 1'b1);
    exp_done_a++;
    @(negedge clk);
    check("busy_fall", {busy_a, done_a}, 2'b00);
    if (inj) check("ovf_sticky", ovf_a, 1'b1);
    n = 0;
    while (busy_b && n < LIMIT) begin @(negedge clk); n++; end
    check("b_idle", busy_b, 1'b0);
    exp_done_b++;
    repeat (3) @(negedge clk);
    check("rd_left", rd_q.size(), 0);
    check("wr_left", exp_q.size(), 0);
    check("wr_left_b", exp_q_b.size(), 0);
    check("rd_cnt_b", rd_cnt_b, 2 * NPIX);
    check("done_cnt_a", done_cnt_a, exp_done_a);
    check("done_cnt_b", done_cnt_b, exp_done_b);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  addr_vec_t avec [6];
  job_vec_t  jvec [4];

  initial begin
    avec[0] = '{0, 2, 16'd2, 16'd2,  16'd6};
    avec[1] = '{2, 3, 16'd7, 16'd11, 16'd11};
    avec[2] = '{1, 0, 16'd0, 16'd4,  16'd8};
    avec[3] = '{1, 3, 16'd3, 16'd7,  16'd11};
    avec[4] = '{0, 0, 16'd0, 16'd0,  16'd4};
    avec[5] = '{2, 0, 16'd4, 16'd8,  16'd8};
    jvec[0] = '{1'b0, 2, 1'b0, OP_ERODE,  OP_DILATE};
    jvec[1] = '{1'b1, 1, 1'b1, OP_DILATE, OP_ERODE};
    jvec[2] = '{1'b0, 3, 1'b1, OP_ERODE,  OP_DILATE};
    jvec[3] = '{1'b1, 2, 1'b0, OP_DILATE, OP_ERODE};

    repeat (3) @(posedge clk);
    #1;
    check("reset_outs_a", {busy_a, done_a, kop_a, kvi_a, rd_en_a, rd_bank_a, a1_a, a2_a, a3_a,
                           wr_en_a, wr_bank_a, wr_addr_a, ovf_a}, '0);
    check("reset_state_a", state_a, ST_IDLE);
    check("reset_outs_b", {busy_b, done_b, rd_en_b, wr_en_b, wr_bank_b, ovf_b}, '0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      log_en = (i == 0);
      run_job(jvec[i].mode, jvec[i].klat, jvec[i].stray, 1'b0);
      check("pass1_op", pass_op[0], jvec[i].op1);
      check("pass2_op", pass_op[1], jvec[i].op2);
    end
    log_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("tbl_addr1", obs1[avec[i].r * W + avec[i].c], avec[i].a1);
      check("tbl_addr2", obs2[avec[i].r * W + avec[i].c], avec[i].a2);
      check("tbl_addr3", obs3[avec[i].r * W + avec[i].c], avec[i].a3);
    end

    // overflow: one extra kernel output after the pass-1 frame, then a fresh start clears it
    run_job(1'b0, 2, 1'b0, 1'b1);
    run_job(1'b0, 1, 1'b0, 1'b0);

    // asynchronous reset in the middle of pass 1
    wait_idle();
    load_job(1'b0);
    @(posedge clk); #1; start = 1'b1; mode = 1'b0; start_cyc = cyc;
    @(posedge clk); #1; start = 1'b0;
    repeat (6) @(negedge clk);
    #2; rst_n = 1'b0;
    #1;
    check("async_reset_a", {busy_a, done_a, kop_a, kvi_a, rd_en_a, rd_bank_a, a1_a, a2_a, a3_a,
                            wr_en_a, wr_bank_a, wr_addr_a, ovf_a}, '0);
    check("async_reset_b", {busy_b, rd_en_b, kvi_b, a2_b, wr_en_b}, '0);
    rd_q.delete(); exp_q.delete(); exp_q_b.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_job(1'b1, 2, 1'b0, 1'b0);

    // randomized jobs
    for (int j = 0; j < 10; j++) begin
      repeat ($urandom_range(0, 4)) @(posedge clk);
      run_job(1'($urandom_range(0, 1)), $urandom_range(1, 3), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
